// File: rtl/cpu24_pkg.sv
// Shared constants and types for the 24-bit datapath blocks.
package cpu24_pkg;
  localparam int WIDTH_DATA  = 24;
  localparam int DEPTH_DEMUX = 2;

  localparam logic ROUTE_1 = 1'b0;
  localparam logic ROUTE_2 = 1'b1;

  typedef logic [$clog2(DEPTH_DEMUX+1)-1:0] fifo_cnt_t;
  localparam fifo_cnt_t CNT_EMPTY = fifo_cnt_t'(0);
  localparam fifo_cnt_t CNT_ONE   = fifo_cnt_t'(1);
  localparam fifo_cnt_t CNT_FULL  = fifo_cnt_t'(DEPTH_DEMUX);
endpackage

// File: rtl/fifo_2hyrje.sv
// Two-entry FIFO with a registered head word; count is exported so the
// parent can build its ready without a combinational path through the pop side.
module fifo_2hyrje
  import cpu24_pkg::*;
#(
  parameter int WIDTH = WIDTH_DATA
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_valid,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output fifo_cnt_t        count
);
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  fifo_cnt_t        count_q, count_d;
  logic             push, pop;

  // Full means not ready even when a pop happens this cycle: no pass-through.
  assign push = push_valid && (count_q != CNT_FULL);
  assign pop  = pop_ready && (count_q != CNT_EMPTY);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == CNT_EMPTY) head_d = push_data;
        else                      tail_d = push_data;
        count_d = count_q + CNT_ONE;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - CNT_ONE;
      end
      2'b11: begin
        head_d = (count_q == CNT_ONE) ? push_data : tail_q;
        tail_d = push_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_EMPTY;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign pop_data  = head_q;
  assign pop_valid = (count_q != CNT_EMPTY);
  assign count     = count_q;
endmodule

// File: rtl/demux_1ne2_stream.sv
// Registered 1-to-2 stream demultiplexer: S steers each word into one of two
// independent 2-entry buffers; each output keeps a saturating delivery count.
module demux_1ne2_stream
  import cpu24_pkg::*;
#(
  parameter int WIDTH = WIDTH_DATA,
  parameter int CNT_W = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Hyrja,
  input  logic             HyrjaValid,
  input  logic             S,
  output logic             HyrjaReady,
  output logic [WIDTH-1:0] Dalja1,
  output logic [WIDTH-1:0] Dalja2,
  output logic             Dalja1Valid,
  output logic             Dalja2Valid,
  input  logic             Dalja1Ready,
  input  logic             Dalja2Ready,
  output logic [CNT_W-1:0] Numeruesi1,
  output logic [CNT_W-1:0] Numeruesi2,
  input  logic             Clear
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  fifo_cnt_t        count1, count2;
  logic             push1, push2;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic [CNT_W-1:0] cnt2_q, cnt2_d;

  assign push1 = HyrjaValid && (S == ROUTE_1);
  assign push2 = HyrjaValid && (S == ROUTE_2);

  // Only combinational output path: S selects which buffer's fill decides ready.
  assign HyrjaReady = (S == ROUTE_1) ? (count1 != CNT_FULL) : (count2 != CNT_FULL);

  fifo_2hyrje #(.WIDTH(WIDTH)) u_fifo1 (
    .clk        (Clock),
    .rst        (Reset),
    .push_data  (Hyrja),
    .push_valid (push1),
    .pop_data   (Dalja1),
    .pop_valid  (Dalja1Valid),
    .pop_ready  (Dalja1Ready),
    .count      (count1)
  );

  fifo_2hyrje #(.WIDTH(WIDTH)) u_fifo2 (
    .clk        (Clock),
    .rst        (Reset),
    .push_data  (Hyrja),
    .push_valid (push2),
    .pop_data   (Dalja2),
    .pop_valid  (Dalja2Valid),
    .pop_ready  (Dalja2Ready),
    .count      (count2)
  );

  // Clear takes priority over a same-cycle delivery.
  always_comb begin
    cnt1_d = cnt1_q;
    cnt2_d = cnt2_q;
    if (Clear) begin
      cnt1_d = '0;
      cnt2_d = '0;
    end else begin
      if (Dalja1Valid && Dalja1Ready && (cnt1_q != CNT_MAX)) cnt1_d = cnt1_q + CNT_W'(1);
      if (Dalja2Valid && Dalja2Ready && (cnt2_q != CNT_MAX)) cnt2_d = cnt2_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
    end else begin
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
    end
  end

  assign Numeruesi1 = cnt1_q;
  assign Numeruesi2 = cnt2_q;
endmodule

// File: doc/demux_1ne2_stream.md
# demux_1ne2_stream

Registered 1-to-2 demultiplexer for the 24-bit datapath: the inverse of the 2-to-1 selection used on operand and write-back paths. It accepts one valid/ready input stream and steers each word, by a select bit sampled with the word, into one of two output streams. Each output has its own 2-entry buffer, so a stalled destination does not corrupt or reorder the other. It sits between the ALU/result bus and its two consumers: the register-file write port on output 1 and the memory/store path on output 2.

## Interface
- WIDTH, 24, data word width in bits
- CNT_W, 16, width of the per-output transfer counters

- Clock  in  1  single clock for all state, rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Hyrja  in  WIDTH  input data word
- HyrjaValid  in  1  input word present
- S  in  1  route select, sampled with Hyrja; 0 sends the word to output 1, 1 sends it to output 2
- HyrjaReady  out  1  block accepts the input word this cycle
- Dalja1, Dalja2  out  WIDTH  head word of output buffer 1 / 2
- Dalja1Valid, Dalja2Valid  out  1  output buffer 1 / 2 non-empty
- Dalja1Ready, Dalja2Ready  in  1  consumer 1 / 2 takes the head word
- Numeruesi1, Numeruesi2  out  CNT_W  saturating count of words delivered on output 1 / 2
- Clear  in  1  synchronous clear of both counters

## Operation
- **Input handshake.** An input transfer happens when HyrjaValid and HyrjaReady are both 1 at a rising Clock edge.
  - HyrjaReady = (S==0) ? (count1<2) : (count2<2). It is combinational from S and the buffer counts.
- **Routing.** An accepted word is pushed only into the buffer chosen by S. The other buffer is untouched.
- **Output handshake.** An output k transfer happens when DaljakValid and DaljakReady are both 1. The head word pops, and the next entry, if any, becomes the head.
- **Buffers.** Each buffer is a 2-entry FIFO and preserves order within its output.
  - A word has no ordering relation to words on the other output.
- **Counters.** Numeruesik increments by 1 on each output-k transfer and holds at all-ones (saturates).
  - Clear=1 zeroes both counters at the edge. Clear wins over a simultaneous increment.
- **Boundary conditions.**
  - Push and pop on the same buffer in the same cycle at count 1: the count stays 1, the old head leaves, and the new word becomes the head.
  - Full buffer (count 2): HyrjaReady=0 for that route even if a pop happens in the same cycle. There is no pass-through when full.
  - Empty buffer: DaljakValid=0, and Daljak is don't-care except after reset.
  - HyrjaValid=0: no push. HyrjaReady still reflects the S route.
  - Popping an empty buffer, i.e. Ready with Valid=0, has no effect.
  - Reset mid-operation: all buffered words are discarded and counters are zeroed immediately. There is no recovery of in-flight data.

## Timing
- Reset values:
  - HyrjaReady=1 for either S value.
  - Dalja1Valid=Dalja2Valid=0.
  - Dalja1=Dalja2=0.
  - Numeruesi1=Numeruesi2=0.
- Latency: a word accepted at edge N appears on Daljak with DaljakValid=1 after edge N, when the buffer was empty. It can pop at edge N+1 at the earliest.
- Throughput: one word per cycle per output when the consumer holds Ready=1.
  - The input can alternate S every cycle with no bubbles.
- Counter increments become visible after the edge of the transfer.
- Combinational paths: S to HyrjaReady only. All other outputs are registered.

## Structure
- Shared package `cpu24_pkg`:
  - WIDTH_DATA=24.
  - FIFO depth constant DEPTH_DEMUX=2.
  - Route encoding constants ROUTE_1=1'b0 and ROUTE_2=1'b1.
- Sub-module `fifo_2hyrje`:
  - 2-entry FIFO with valid/ready on both sides, exposing its count.
  - Instantiated twice; push is gated by the route decode.
- The top level holds the route decode, the HyrjaReady mux and the two saturating counters.

## Test plan
- **Basic routing:** after reset, send 24'h0000A1 with S=0, then 24'h0000B2 with S=1, both Ready=1.
  - Dalja1=A1 and Dalja2=B2, each valid one cycle after its accept.
  - Counters are 1 and 1.
- **Stall isolation:** Dalja1Ready=0, then send 3 words with S=0.
  - Words 1 and 2 are accepted. On the 3rd, HyrjaReady=0.
  - Set S=1: HyrjaReady=1 and the word lands on output 2.
- **Full-buffer pop:** output 1 full and Dalja1Ready=1 in the same cycle as an S=0 input.
  - The input is not accepted. It is accepted next cycle, and order is preserved: 1, 2, 3.
- **Alternating throughput:** 100 words with S toggling each cycle and both Ready=1.
  - Zero bubbles on the input.
  - Counters end at 50 and 50.
  - Per-output sequences match.
- **Saturation and Clear:** force 65,540 transfers on output 1.
  - Numeruesi1 holds at 16'hFFFF.
  - Clear=1 together with a transfer leaves 0.
- **Reset mid-flight:** two words buffered in output 2, then assert Reset asynchronously mid-cycle.
  - Dalja2Valid drops to 0 immediately, counters read 0, and HyrjaReady=1.
